// File: rtl/memarb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   state_e  : arbiter FSM states (IDLE, I_WAIT, D_WAIT)
//   winner_e : result of one arbitration cycle
//   STARVE_LIMIT_DEFAULT / STARVE_CNT_W : starvation counter defaults
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_I    = 2'd1,
    WIN_D    = 2'd2
  } winner_e;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned STARVE_CNT_W         = 4;

endpackage : memarb_pkg

// File: rtl/memarb_grant.sv
// Grant selection and instruction-starvation counter.
// Data wins by default; once STARVE_LIMIT data grants have been given while an
// instruction request was waiting, the instruction wins the next grant.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   arb_en     : a grant may be issued this cycle (FSM idle, memory ready)
//   i_start    : instruction request pending
//   d_start    : data request pending
//   winner     : which requester is granted this cycle (combinational)
module memarb_grant
  import memarb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    arb_en,
  input  logic    i_start,
  input  logic    d_start,
  output winner_e winner
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = 4'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    winner = WIN_NONE;
    if (arb_en) begin
      if (d_start && !(i_start && (starve_cnt_q == LIMIT))) begin
        winner = WIN_D;
      end else if (i_start) begin
        winner = WIN_I;
      end
    end
  end

  // Counts data grants made while a fetch is waiting; any cycle without a
  // fetch request, or a fetch grant, restarts the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_start || (winner == WIN_I)) begin
      starve_cnt_d = '0;
    end else if ((winner == WIN_D) && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule : memarb_grant

// File: rtl/memory_arbiter.sv
// Two-requester arbiter in front of a single memory port: an instruction fetch
// port (read-only) and a load/store data port share one memory. One command
// is granted per cycle while idle; a granted read waits for m_rvalid before
// another grant, a granted write completes in its grant cycle.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   i_start/i_ready/i_addr     : fetch command handshake and address
//   i_rdata/i_rvalid           : fetch read return
//   d_start/d_write/d_ready    : data command handshake and direction
//   d_addr/d_wdata/d_wmask     : data command payload
//   d_rdata/d_rvalid           : data read return
//   m_start/m_write/m_ready    : memory command handshake and direction
//   m_addr/m_wdata/m_wmask     : memory command payload
//   m_rdata/m_rvalid           : memory read return
module memory_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction port
  input  logic        i_start,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  // data port
  input  logic        d_start,
  input  logic        d_write,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  // memory port
  output logic        m_start,
  output logic        m_write,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [31:0] m_wmask,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid
);

  state_e  state_q, state_d;
  winner_e winner;
  logic    arb_en;

  // Gating with rst_n keeps every output at zero while reset is held, even
  // though the command path is purely combinational.
  assign arb_en = rst_n && (state_q == IDLE) && m_ready;

  memarb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
    .i_start (i_start),
    .d_start (d_start),
    .winner  (winner)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A return arriving in a wait state is consumed there;
  // the next grant can only be made from IDLE in a later cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (winner == WIN_I) begin
          state_d = I_WAIT;
        end else if ((winner == WIN_D) && !d_write) begin
          state_d = D_WAIT;
        end
      end
      I_WAIT, D_WAIT: begin
        if (m_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: command mux towards memory, return routing to requesters.
  always_comb begin
    m_start  = 1'b0;
    m_write  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wmask  = '0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    unique case (winner)
      WIN_I: begin
        m_start = 1'b1;
        m_addr  = i_addr;
        i_ready = m_ready;
      end
      WIN_D: begin
        m_start = 1'b1;
        m_write = d_write;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_wmask = d_wmask;
        d_ready = m_ready;
      end
      default: ;
    endcase

    i_rvalid = m_rvalid && (state_q == I_WAIT);
    d_rvalid = m_rvalid && (state_q == D_WAIT);
    i_rdata  = rst_n ? m_rdata : '0;
    d_rdata  = rst_n ? m_rdata : '0;
  end

endmodule : memory_arbiter

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, setting the maximum consecutive data grants while an instruction request waits (range 1..15).
REQ-002 The block SHALL have port clk  input  1  the single clock, rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have instruction ports i_start in 1, i_ready out 1, i_addr in 32, i_rdata out 32, i_rvalid out 1, for a read-only fetch requester.
REQ-005 The block SHALL have data ports d_start in 1, d_write in 1, d_ready out 1, d_addr in 32, d_wdata in 32, d_wmask in 32, d_rdata out 32, d_rvalid out 1, for a load/store requester.
REQ-006 The block SHALL have memory ports m_start out 1, m_write out 1, m_ready in 1, m_addr out 32, m_wdata out 32, m_wmask out 32, m_rdata in 32, m_rvalid in 1, for the single shared memory.

Function
REQ-007 A command SHALL transfer in a cycle where start and ready are both high; requesters SHALL NOT derive start from ready.
REQ-008 The FSM SHALL have states IDLE, I_WAIT and D_WAIT.
REQ-009 In IDLE with m_ready high, the block SHALL grant one requester per cycle: data wins unless i_start is pending and the starvation counter equals STARVE_LIMIT.
REQ-010 On grant, the block SHALL drive m_start high and route the winner's addr/wdata/wmask/write to the m_* outputs in the same cycle (zero-cycle combinational path).
REQ-011 The winner's ready SHALL equal m_ready in that cycle; the loser's ready SHALL be low.
REQ-012 Outside a grant, m_start, m_write, i_ready and d_ready SHALL be low; m_addr, m_wdata and m_wmask SHALL be 0.
REQ-013 A granted instruction read SHALL move IDLE->I_WAIT; a granted data read (d_write=0) SHALL move IDLE->D_WAIT; a granted write SHALL remain in IDLE (no response expected).
REQ-014 In I_WAIT/D_WAIT, no new grant SHALL be issued; m_rvalid SHALL return the FSM to IDLE.
REQ-015 i_rvalid SHALL equal m_rvalid AND state==I_WAIT; d_rvalid SHALL equal m_rvalid AND state==D_WAIT; i_rdata and d_rdata SHALL both equal m_rdata (0-cycle pass-through).
REQ-016 m_rvalid in IDLE SHALL be ignored (no rvalid forwarded, no state change).
REQ-017 Starvation counter (4 bits): increments on a data grant while i_start is high, saturating at STARVE_LIMIT; clears on any instruction grant or any cycle with i_start low.
REQ-018 Simultaneous m_rvalid and new requests: the return SHALL be consumed that cycle, and the new grant SHALL occur no earlier than the following cycle.
REQ-019 A request with m_ready low SHALL be held by the requester; the block SHALL NOT latch it.

Reset
REQ-020 On rst_n low, the block SHALL immediately force state IDLE and counter 0, and all outputs SHALL be 0.
REQ-021 Reset asserted during I_WAIT/D_WAIT SHALL abandon the outstanding read; a later stray m_rvalid SHALL be dropped per REQ-016.
REQ-022 The first grant SHALL be possible in the first rising edge after rst_n deasserts.

Structure
REQ-023 The state enum and STARVE_LIMIT default SHALL live in shared package memarb_pkg.
REQ-024 Grant selection plus the starvation counter SHALL be one sub-module, memarb_grant; the FSM and muxing SHALL stay in memory_arbiter.
REQ-025 The block SHALL sit between Core's instruction/data ports and the memory; Core SHALL need no change.

Verification
REQ-026 i_start only, i_addr=0x100, m_ready=1, m_rdata=0x00000013 after 2 cycles -> i_ready=1 in cycle 0, i_rvalid=1 with i_rdata=0x13, d_rvalid=0.
REQ-027 i_start and d_start both high, read at d_addr=0x2000 -> data granted first (m_addr=0x2000), instruction granted the cycle after the data return.
REQ-028 Store d_write=1, d_wmask=0x0000FFFF, d_wdata=0xBEEF -> single-cycle grant, FSM stays IDLE, instruction grant possible in the next cycle.
REQ-029 d_start held for continuous stores with i_start high and STARVE_LIMIT=4 -> after 4 data grants, the 5th grant goes to the instruction; the counter then reads 0.
REQ-030 rst_n pulsed low in D_WAIT, m_rvalid=1 one cycle after release -> d_rvalid stays 0, state IDLE, all outputs 0 during reset.
